// File: rtl/riscv_pkg.sv
// Shared definitions for the memory-access stage:
// funct3 codes, result_src encodings, FSM states, MEM/WB bundle.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RS_ALU  = 2'b00;
    localparam logic [1:0] RS_LOAD = 2'b01;
    localparam logic [1:0] RS_PC4  = 2'b10;
    localparam logic [1:0] RS_RSVD = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } mem_state_e;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [31:0] pc_plus_4;
        logic [4:0]  rd;
        logic        regwrite;
        logic [1:0]  result_src;
    } mem_wb_t;

    localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane handling for loads and stores: store replication and
// strobes, load lane select and extension, misalign/illegal detect.
module load_store_align
    import riscv_pkg::*;
(
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] load_data_o,
    output logic        misaligned_o,
    output logic        illegal_o
);

    logic [31:0] rshift;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign rshift = rdata_i >> {lane_i, 3'b000};
    assign byte_v = rshift[7:0];
    assign half_v = rshift[15:0];

    // Decode access size and build lane-adjusted data in both directions.
    always_comb begin
        wdata_o      = store_data_i;
        wstrb_o      = 4'b0000;
        load_data_o  = rdata_i;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        case (funct3_i)
            F3_B: begin
                wdata_o     = {4{store_data_i[7:0]}};
                wstrb_o     = 4'b0001 << lane_i;
                load_data_o = {{24{byte_v[7]}}, byte_v};
            end
            F3_H: begin
                wdata_o      = {2{store_data_i[15:0]}};
                wstrb_o      = 4'b0011 << lane_i;
                load_data_o  = {{16{half_v[15]}}, half_v};
                misaligned_o = lane_i[0];
            end
            F3_W: begin
                wstrb_o      = 4'b1111;
                misaligned_o = (lane_i != 2'b00);
            end
            F3_BU: begin
                load_data_o = {24'b0, byte_v};
                illegal_o   = is_store_i;
            end
            F3_HU: begin
                load_data_o  = {16'b0, half_v};
                misaligned_o = lane_i[0];
                illegal_o    = is_store_i;
            end
            default: illegal_o = 1'b1;
        endcase
        if (!is_store_i) begin
            wstrb_o = 4'b0000;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: data-memory handshake with timeout,
// MEM/WB register and M-stage forwarding/stall outputs.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] writedata_m,
    input  logic [31:0] pc_plus_4_m,
    input  logic [4:0]  rd_m_in,
    input  logic        regwrite_m_in,
    input  logic [1:0]  result_src_m,
    input  logic        memwrite_m,
    input  logic [2:0]  funct3_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall_m,
    output logic        mem_fault_m,
    output logic [4:0]  rd_m,
    output logic        regwrite_m,
    output logic [31:0] mem_wb_alu_result,
    output logic [31:0] mem_wb_read_data,
    output logic [31:0] mem_wb_pc_plus_4,
    output logic [4:0]  mem_wb_rd,
    output logic        mem_wb_regwrite,
    output logic [1:0]  mem_wb_result_src
);

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    mem_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    mem_wb_t     mem_wb_q, mem_wb_d;

    logic        mem_op;
    logic        bad_access;
    logic        done;
    logic [31:0] load_data;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        misaligned;
    logic        illegal;

    assign mem_op     = memwrite_m | (result_src_m == RS_LOAD);
    assign bad_access = misaligned | illegal;

    load_store_align u_align (
        .is_store_i   (memwrite_m),
        .funct3_i     (funct3_m),
        .lane_i       (alu_result_m[1:0]),
        .store_data_i (writedata_m),
        .rdata_i      (dmem_rdata),
        .wdata_o      (wdata),
        .wstrb_o      (wstrb),
        .load_data_o  (load_data),
        .misaligned_o (misaligned),
        .illegal_o    (illegal)
    );

    // Request/wait sequencing; the timeout slot drops the request.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dmem_req    = 1'b0;
        mem_fault_m = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op && bad_access) begin
                    mem_fault_m = 1'b1;
                end else if (mem_op) begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        done = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 16'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == TMO) begin
                    mem_fault_m = 1'b1;
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                end else begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign stall_m    = dmem_req & ~dmem_ready;
    assign dmem_we    = dmem_req & memwrite_m;
    assign dmem_addr  = {alu_result_m[31:2], 2'b00};
    assign dmem_wdata = wdata;
    assign dmem_wstrb = dmem_we ? wstrb : 4'b0000;
    assign rd_m       = rd_m_in;
    assign regwrite_m = regwrite_m_in;

    // MEM/WB next value: bubble on stall or fault, else the instruction.
    always_comb begin
        mem_wb_d = MEM_WB_BUBBLE;
        if (!stall_m && !mem_fault_m) begin
            mem_wb_d.alu_result = alu_result_m;
            mem_wb_d.read_data  = (done && !memwrite_m) ? load_data : '0;
            mem_wb_d.pc_plus_4  = pc_plus_4_m;
            mem_wb_d.rd         = rd_m_in;
            mem_wb_d.regwrite   = regwrite_m_in & (rd_m_in != 5'd0);
            mem_wb_d.result_src = (result_src_m == RS_RSVD) ? RS_ALU
                                                            : result_src_m;
        end
    end

    // State, timeout counter and MEM/WB register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mem_wb_q <= MEM_WB_BUBBLE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign mem_wb_alu_result = mem_wb_q.alu_result;
    assign mem_wb_read_data  = mem_wb_q.read_data;
    assign mem_wb_pc_plus_4  = mem_wb_q.pc_plus_4;
    assign mem_wb_rd         = mem_wb_q.rd;
    assign mem_wb_regwrite   = mem_wb_q.regwrite;
    assign mem_wb_result_src = mem_wb_q.result_src;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected MEM/WB entries are queued
// when an instruction is applied and compared when it retires.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_result_m, writedata_m, pc_plus_4_m;
    logic [4:0]  rd_m_in;
    logic        regwrite_m_in;
    logic [1:0]  result_src_m;
    logic        memwrite_m;
    logic [2:0]  funct3_m;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall_m, mem_fault_m;
    logic [4:0]  rd_m;
    logic        regwrite_m;
    logic [31:0] mem_wb_alu_result, mem_wb_read_data, mem_wb_pc_plus_4;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_regwrite;
    logic [1:0]  mem_wb_result_src;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  src;
    } wb_t;

    wb_t sb_q[$];
    wb_t got, exp;
    int  vectors = 0;
    int  errors  = 0;
    int  commits = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .alu_result_m(alu_result_m), .writedata_m(writedata_m),
        .pc_plus_4_m(pc_plus_4_m), .rd_m_in(rd_m_in),
        .regwrite_m_in(regwrite_m_in), .result_src_m(result_src_m),
        .memwrite_m(memwrite_m), .funct3_m(funct3_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .stall_m(stall_m), .mem_fault_m(mem_fault_m),
        .rd_m(rd_m), .regwrite_m(regwrite_m),
        .mem_wb_alu_result(mem_wb_alu_result),
        .mem_wb_read_data(mem_wb_read_data),
        .mem_wb_pc_plus_4(mem_wb_pc_plus_4),
        .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
        .mem_wb_result_src(mem_wb_result_src)
    );

    // Count committed stores (handshake completes on a write).
    always @(posedge clk) begin
        if (dmem_req && dmem_we && dmem_ready) commits++;
    end

    // Hard stop in case something upstream never returns.
    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded", $time);
        $fatal(1);
    end

    function automatic wb_t mk(input logic [31:0] alu, rdata, pc4,
                               input logic [4:0] rd, input logic rw,
                               input logic [1:0] src);
        mk = '{alu: alu, rdata: rdata, pc4: pc4, rd: rd, rw: rw, src: src};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] addr, wd, pc4,
                         input logic [4:0] rd, input logic rw,
                         input logic [1:0] src, input logic mw,
                         input logic [2:0] f3);
        alu_result_m  = addr;
        writedata_m   = wd;
        pc_plus_4_m   = pc4;
        rd_m_in       = rd;
        regwrite_m_in = rw;
        result_src_m  = src;
        memwrite_m    = mw;
        funct3_m      = f3;
    endtask

    task automatic nop;
        drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 3'b000);
    endtask

    // Holds ready low for 'waits' cycles then completes the access.
    task automatic mem_cycles(input int waits, input logic [31:0] rdata,
                              output int stalls, output int bubbles);
        stalls  = 0;
        bubbles = 0;
        for (int i = 0; i < waits; i++) begin
            dmem_ready = 1'b0;
            #1;
            if (stall_m) stalls++;
            step;
            if (!mem_wb_regwrite && mem_wb_rd == 5'd0) bubbles++;
        end
        dmem_ready = 1'b1;
        dmem_rdata = rdata;
        step;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h5A5A_5A5A;
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        nop;
        step;
        step;
        vectors++;
        if ({dmem_req, stall_m, mem_fault_m, mem_wb_alu_result,
             mem_wb_read_data, mem_wb_pc_plus_4, mem_wb_rd,
             mem_wb_regwrite, mem_wb_result_src} !== 107'd0) begin
            errors++;
            $display("FAIL reset: wb=%h/%h/%h rd=%0d rw=%b req=%b",
                     mem_wb_alu_result, mem_wb_read_data, mem_wb_pc_plus_4,
                     mem_wb_rd, mem_wb_regwrite, dmem_req);
        end
        reset = 1'b0;
    endtask

    task automatic test_alu;
        logic [31:0] a[3] = '{32'h0000_1234, 32'h0000_DEAD, 32'h0000_0010};
        logic [31:0] p[3] = '{32'h44, 32'h48, 32'h4C};
        logic [4:0]  r[3] = '{5'd5, 5'd0, 5'd1};
        logic [1:0]  s[3] = '{2'b00, 2'b11, 2'b10};
        logic [4:0]  er[3] = '{5'd5, 5'd0, 5'd1};
        logic        ew[3] = '{1'b1, 1'b0, 1'b1};
        logic [1:0]  es[3] = '{2'b00, 2'b00, 2'b10};
        for (int i = 0; i < 3; i++) begin
            drive(a[i], 32'hFFFF_FFFF, p[i], r[i], 1'b1, s[i], 1'b0, 3'b010);
            dmem_ready = 1'b1;
            sb_q.push_back(mk(a[i], 32'h0, p[i], er[i], ew[i], es[i]));
            #1;
            vectors++;
            if ({dmem_req, stall_m, rd_m, regwrite_m} !== {2'b00, r[i], 1'b1}) begin
                errors++;
                $display("FAIL alu_fwd[%0d]: req=%b stall=%b rd_m=%0d rw_m=%b",
                         i, dmem_req, stall_m, rd_m, regwrite_m);
            end
            step;
            exp = sb_q.pop_front();
            got = {mem_wb_alu_result, mem_wb_read_data, mem_wb_pc_plus_4,
                   mem_wb_rd, mem_wb_regwrite, mem_wb_result_src};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL alu_wb[%0d]: got %h exp %h", i, got, exp);
            end
        end
        dmem_ready = 1'b0;
    endtask

    task automatic test_store;
        logic [31:0] a[3]  = '{32'h103, 32'h206, 32'h300};
        logic [31:0] d[3]  = '{32'h0000_00AB, 32'h1234_BEEF, 32'hCAFE_0123};
        logic [2:0]  f[3]  = '{3'b000, 3'b001, 3'b010};
        int          w[3]  = '{0, 1, 0};
        logic [31:0] ea[3] = '{32'h100, 32'h204, 32'h300};
        logic [31:0] ed[3] = '{32'hABAB_ABAB, 32'hBEEF_BEEF, 32'hCAFE_0123};
        logic [3:0]  es[3] = '{4'b1000, 4'b1100, 4'b1111};
        int c0, stalls, bubbles;
        for (int i = 0; i < 3; i++) begin
            drive(a[i], d[i], 32'h50, 5'd0, 1'b0, 2'b00, 1'b1, f[i]);
            sb_q.push_back(mk(a[i], 32'h0, 32'h50, 5'd0, 1'b0, 2'b00));
            c0 = commits;
            dmem_ready = (w[i] == 0);
            #1;
            vectors++;
            if ({dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata, stall_m}
                !== {2'b11, ea[i], es[i], ed[i], (w[i] != 0)}) begin
                errors++;
                $display("FAIL store_bus[%0d]: addr=%h wstrb=%b wdata=%h stall=%b",
                         i, dmem_addr, dmem_wstrb, dmem_wdata, stall_m);
            end
            mem_cycles(w[i], 32'h0, stalls, bubbles);
            vectors++;
            if (commits - c0 != 1 || stalls != w[i]) begin
                errors++;
                $display("FAIL store_commit[%0d]: commits=%0d stalls=%0d exp 1/%0d",
                         i, commits - c0, stalls, w[i]);
            end
            exp = sb_q.pop_front();
            got = {mem_wb_alu_result, mem_wb_read_data, mem_wb_pc_plus_4,
                   mem_wb_rd, mem_wb_regwrite, mem_wb_result_src};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL store_wb[%0d]: got %h exp %h", i, got, exp);
            end
        end
    endtask

    task automatic test_load;
        logic [31:0] a[5]  = '{32'h202, 32'h202, 32'h101, 32'h103, 32'h400};
        logic [2:0]  f[5]  = '{3'b001, 3'b101, 3'b000, 3'b100, 3'b010};
        logic [31:0] rd[5] = '{32'h8001_0000, 32'h8001_0000, 32'h0000_F000,
                               32'h7F00_0000, 32'hCAFE_F00D};
        int          w[5]  = '{2, 0, 1, 0, 1};
        logic [31:0] ev[5] = '{32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_FFF0,
                               32'h0000_007F, 32'hCAFE_F00D};
        int stalls, bubbles;
        for (int i = 0; i < 5; i++) begin
            drive(a[i], 32'h0, 32'h60 + 32'(i), 5'd7, 1'b1, 2'b01, 1'b0, f[i]);
            sb_q.push_back(mk(a[i], ev[i], 32'h60 + 32'(i), 5'd7, 1'b1, 2'b01));
            dmem_ready = 1'b0;
            #1;
            vectors++;
            if ({dmem_req, dmem_we, dmem_addr, dmem_wstrb}
                !== {2'b10, a[i][31:2], 2'b00, 4'b0000}) begin
                errors++;
                $display("FAIL load_bus[%0d]: req=%b we=%b addr=%h wstrb=%b",
                         i, dmem_req, dmem_we, dmem_addr, dmem_wstrb);
            end
            mem_cycles(w[i], rd[i], stalls, bubbles);
            vectors++;
            if (stalls != w[i] || bubbles != w[i]) begin
                errors++;
                $display("FAIL load_wait[%0d]: stalls=%0d bubbles=%0d exp %0d",
                         i, stalls, bubbles, w[i]);
            end
            exp = sb_q.pop_front();
            got = {mem_wb_alu_result, mem_wb_read_data, mem_wb_pc_plus_4,
                   mem_wb_rd, mem_wb_regwrite, mem_wb_result_src};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL load_wb[%0d]: got %h exp %h", i, got, exp);
            end
        end
    endtask

    task automatic test_fault;
        logic [31:0] a[4] = '{32'h301, 32'h105, 32'h200, 32'h200};
        logic [2:0]  f[4] = '{3'b010, 3'b001, 3'b011, 3'b100};
        logic        m[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int c0;
        for (int i = 0; i < 4; i++) begin
            c0 = commits;
            drive(a[i], 32'h1111_2222, 32'h70, 5'd3, 1'b1,
                  m[i] ? 2'b00 : 2'b01, m[i], f[i]);
            sb_q.push_back(mk(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00));
            dmem_ready = 1'b1;
            #1;
            vectors++;
            if ({dmem_req, stall_m, mem_fault_m} !== 3'b001) begin
                errors++;
                $display("FAIL fault_comb[%0d]: req=%b stall=%b fault=%b exp 0/0/1",
                         i, dmem_req, stall_m, mem_fault_m);
            end
            step;
            dmem_ready = 1'b0;
            exp = sb_q.pop_front();
            got = {mem_wb_alu_result, mem_wb_read_data, mem_wb_pc_plus_4,
                   mem_wb_rd, mem_wb_regwrite, mem_wb_result_src};
            vectors++;
            if (got !== exp || commits != c0) begin
                errors++;
                $display("FAIL fault_wb[%0d]: got %h exp %h commits=%0d",
                         i, got, exp, commits - c0);
            end
            nop;
            #1;
            vectors++;
            if (mem_fault_m !== 1'b0) begin
                errors++;
                $display("FAIL fault_pulse[%0d]: fault=%b exp 0", i, mem_fault_m);
            end
            step;
        end
    endtask

    task automatic test_timeout;
        int stalls = 0;
        int faults = 0;
        logic req_at_fault = 1'b1;
        drive(32'h400, 32'h0, 32'h80, 5'd9, 1'b1, 2'b01, 1'b0, 3'b010);
        sb_q.push_back(mk(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00));
        dmem_ready = 1'b0;
        for (int i = 0; i < 8 && faults == 0; i++) begin
            #1;
            if (stall_m) stalls++;
            if (mem_fault_m) begin
                faults++;
                req_at_fault = dmem_req;
            end
            step;
        end
        vectors++;
        if (stalls != 4 || faults != 1 || req_at_fault !== 1'b0) begin
            errors++;
            $display("FAIL timeout: stalls=%0d faults=%0d req=%b exp 4/1/0",
                     stalls, faults, req_at_fault);
        end
        exp = sb_q.pop_front();
        got = {mem_wb_alu_result, mem_wb_read_data, mem_wb_pc_plus_4,
               mem_wb_rd, mem_wb_regwrite, mem_wb_result_src};
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL timeout_wb: got %h exp %h", got, exp);
        end
        nop;
        #1;
        vectors++;
        if ({dmem_req, mem_fault_m} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_idle: req=%b fault=%b exp 0/0",
                     dmem_req, mem_fault_m);
        end
        step;
        drive(32'h404, 32'h0, 32'h84, 5'd9, 1'b1, 2'b01, 1'b0, 3'b010);
        sb_q.push_back(mk(32'h404, 32'h1122_3344, 32'h84, 5'd9, 1'b1, 2'b01));
        dmem_ready = 1'b1;
        dmem_rdata = 32'h1122_3344;
        #1;
        vectors++;
        if ({dmem_req, stall_m} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_next: req=%b stall=%b exp 1/0",
                     dmem_req, stall_m);
        end
        step;
        dmem_ready = 1'b0;
        exp = sb_q.pop_front();
        got = {mem_wb_alu_result, mem_wb_read_data, mem_wb_pc_plus_4,
               mem_wb_rd, mem_wb_regwrite, mem_wb_result_src};
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL timeout_next_wb: got %h exp %h", got, exp);
        end
    endtask

    task automatic test_reset_wait;
        int stalls, bubbles;
        drive(32'h500, 32'h0, 32'h90, 5'd4, 1'b1, 2'b01, 1'b0, 3'b010);
        dmem_ready = 1'b0;
        step;
        reset = 1'b1;
        nop;
        step;
        reset = 1'b0;
        vectors++;
        if ({dmem_req, mem_wb_alu_result, mem_wb_read_data, mem_wb_pc_plus_4,
             mem_wb_rd, mem_wb_regwrite, mem_wb_result_src} !== 105'd0) begin
            errors++;
            $display("FAIL reset_wait: req=%b wb=%h rd=%0d rw=%b",
                     dmem_req, mem_wb_alu_result, mem_wb_rd, mem_wb_regwrite);
        end
        drive(32'h504, 32'h0, 32'h94, 5'd4, 1'b1, 2'b01, 1'b0, 3'b010);
        sb_q.push_back(mk(32'h504, 32'h0BAD_F00D, 32'h94, 5'd4, 1'b1, 2'b01));
        mem_cycles(1, 32'h0BAD_F00D, stalls, bubbles);
        exp = sb_q.pop_front();
        got = {mem_wb_alu_result, mem_wb_read_data, mem_wb_pc_plus_4,
               mem_wb_rd, mem_wb_regwrite, mem_wb_result_src};
        vectors++;
        if (got !== exp || stalls != 1) begin
            errors++;
            $display("FAIL reset_wait_next: got %h exp %h stalls=%0d",
                     got, exp, stalls);
        end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_store;
        test_load;
        test_fault;
        test_timeout;
        test_reset_wait;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
